ndp_stream_unit: RTL and testbench

//  Self-sequencing near-data GEMM tile engine: integer output-stationary ROWS x COLS MAC grid.

---
 rtl/ndp_stream_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_ndp_stream_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ndp_stream_unit.sv
// ndp_stream_unit: self-sequencing output-stationary ROWS x COLS integer MAC grid.
// Operand beats stream in through valid/ready and are skewed so that PE(r,c)
// sees A[r][k] and B[k][c] together. A zero flush drains the wavefront, and
// the accumulator rows are then returned one at a time through valid/ready.
module ndp_stream_unit #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int KMAX      = 256,
  parameter int KW        = $clog2(KMAX + 1),
  parameter int IW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [KW-1:0]             cfg_k,
  input  logic                      cfg_acc,
  input  logic                      start,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*WIDTH-1:0]     in_a,
  input  logic [COLS*WIDTH-1:0]     in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*ACC_WIDTH-1:0] out_row,
  output logic [IW-1:0]             out_idx,
  output logic                      done
);

  localparam int FW = $clog2(ROWS + COLS);
  localparam logic [KW-1:0] KMAX_K = KW'(KMAX);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
  localparam logic [IW-1:0] ROW_LAST = IW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t state, state_nx;

  logic [KW-1:0] k_cfg;
  logic [KW-1:0] k_cnt;
  logic [FW-1:0] f_cnt;
  logic [KW-1:0] cfg_k_clamped;

  logic clr;
  logic clr_acc;
  logic accept;
  logic step;
  logic last_beat;
  logic flush_end;
  logic xfer;
  logic last_row;

  logic [WIDTH-1:0] a_in [ROWS];
  logic [WIDTH-1:0] b_in [COLS];
  logic [WIDTH-1:0] a_skewed [ROWS];
  logic [WIDTH-1:0] b_skewed [COLS];

  logic [WIDTH-1:0]            a_pipe [ROWS][COLS];
  logic [WIDTH-1:0]            b_pipe [ROWS][COLS];
  logic [ACC_WIDTH-1:0]        acc    [ROWS][COLS];
  logic signed [2*WIDTH-1:0]   mul    [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] prod   [ROWS][COLS];

  assign cfg_k_clamped = (cfg_k > KMAX_K) ? KMAX_K : cfg_k;

  // Handshake and sequencing qualifiers shared by the FSM and the datapath
  always_comb begin
    clr       = (state == IDLE) && start;
    clr_acc   = clr && !cfg_acc;
    accept    = (state == LOAD) && in_valid;
    step      = accept || (state == FLUSH);
    last_beat = accept && (k_cnt == (k_cfg - KW'(1)));
    flush_end = (state == FLUSH) && (f_cnt == FLUSH_LAST);
    xfer      = (state == DRAIN) && out_ready;
    last_row  = xfer && (out_idx == ROW_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and state-decoded status outputs
  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    case (state)
      IDLE:    if (start) state_nx = (cfg_k == '0) ? DRAIN : LOAD;
      LOAD:    if (last_beat) state_nx = FLUSH;
      FLUSH:   if (flush_end) state_nx = DRAIN;
      DRAIN:   if (last_row) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Tile configuration, beat/flush/row counters and the registered done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_cfg   <= '0;
      k_cnt   <= '0;
      f_cnt   <= '0;
      out_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= last_row;
      if (clr) begin
        k_cfg   <= cfg_k_clamped;
        k_cnt   <= '0;
        f_cnt   <= '0;
        out_idx <= '0;
      end else begin
        if (accept) k_cnt <= k_cnt + KW'(1);
        if (state == FLUSH) f_cnt <= f_cnt + FW'(1);
        if (flush_end) out_idx <= '0;
        if (xfer) out_idx <= last_row ? '0 : out_idx + IW'(1);
      end
    end
  end

  // Operand lanes: live beat data while loading, zeros while flushing
  always_comb begin
    for (int r = 0; r < ROWS; r++)
      a_in[r] = (state == LOAD) ? in_a[r*WIDTH +: WIDTH] : '0;
    for (int c = 0; c < COLS; c++)
      b_in[c] = (state == LOAD) ? in_b[c*WIDTH +: WIDTH] : '0;
  end

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
      if (r == 0) begin : g_direct
        assign a_skewed[r] = a_in[r];
      end else begin : g_delay
        logic [WIDTH-1:0] sh [r];
        // A lane r is delayed r grid steps before entering column 0
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            for (int i = 0; i < r; i++) sh[i] <= '0;
          end else if (clr) begin
            for (int i = 0; i < r; i++) sh[i] <= '0;
          end else if (step) begin
            sh[0] <= a_in[r];
            for (int i = 1; i < r; i++) sh[i] <= sh[i-1];
          end
        end
        assign a_skewed[r] = sh[r-1];
      end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
      if (c == 0) begin : g_direct
        assign b_skewed[c] = b_in[c];
      end else begin : g_delay
        logic [WIDTH-1:0] sh [c];
        // B lane c is delayed c grid steps before entering row 0
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            for (int i = 0; i < c; i++) sh[i] <= '0;
          end else if (clr) begin
            for (int i = 0; i < c; i++) sh[i] <= '0;
          end else if (step) begin
            sh[0] <= b_in[c];
            for (int i = 1; i < c; i++) sh[i] <= sh[i-1];
          end
        end
        assign b_skewed[c] = sh[c-1];
      end
    end
  endgenerate

  // Signed WIDTH x WIDTH products, sign-extended to accumulator width
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        mul[r][c]  = (2*WIDTH)'($signed(a_pipe[r][c])) * (2*WIDTH)'($signed(b_pipe[r][c]));
        prod[r][c] = ACC_WIDTH'(mul[r][c]);
      end
    end
  end

  // Systolic grid: A moves right, B moves down, each PE accumulates its product per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_pipe[r][c] <= '0;
          b_pipe[r][c] <= '0;
          acc[r][c]    <= '0;
        end
      end
    end else if (clr) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_pipe[r][c] <= '0;
          b_pipe[r][c] <= '0;
          if (clr_acc) acc[r][c] <= '0;
        end
      end
    end else if (step) begin
      for (int r = 0; r < ROWS; r++) begin
        a_pipe[r][0] <= a_skewed[r];
        for (int c = 1; c < COLS; c++) a_pipe[r][c] <= a_pipe[r][c-1];
      end
      for (int c = 0; c < COLS; c++) begin
        b_pipe[0][c] <= b_skewed[c];
        for (int r = 1; r < ROWS; r++) b_pipe[r][c] <= b_pipe[r-1][c];
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          acc[r][c] <= acc[r][c] + ACC_WIDTH'(prod[r][c]);
        end
      end
    end
  end

  // Result row mux, only driven while draining
  always_comb begin
    out_row = '0;
    if (state == DRAIN) begin
      for (int c = 0; c < COLS; c++) out_row[c*ACC_WIDTH +: ACC_WIDTH] = acc[out_idx][c];
    end
  end

endmodule

// File: tb/tb_ndp_stream_unit.sv
// tb_ndp_stream_unit: directed and randomized tiles checked against a plain
// matrix-product model of the accumulators.
module tb_ndp_stream_unit;

  localparam int WIDTH = 16;
  localparam int ACC_W = 40;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KMAX  = 256;
  localparam int KW    = $clog2(KMAX + 1);
  localparam int IW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int VW    = COLS * ACC_W;

  typedef logic [ACC_W-1:0] acc_t;

  logic                  clk;
  logic                  reset;
  logic [KW-1:0]         cfg_k;
  logic                  cfg_acc;
  logic                  start;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [ROWS*WIDTH-1:0] in_a;
  logic [COLS*WIDTH-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [VW-1:0]         out_row;
  logic [IW-1:0]         out_idx;
  logic                  done;

  ndp_stream_unit #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_W), .ROWS(ROWS), .COLS(COLS), .KMAX(KMAX)
  ) dut (
    .clk(clk), .reset(reset), .cfg_k(cfg_k), .cfg_acc(cfg_acc), .start(start),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] beat_a [KMAX][ROWS];
  logic [WIDTH-1:0] beat_b [KMAX][COLS];
  acc_t             model_c [ROWS][COLS];

  task automatic check_output(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // C = (optionally previous C) + sum over k of A[:,k] * B[k,:]
  task automatic model_tile(input int k, input bit acc_mode);
    longint pa, pb;
    if (!acc_mode)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) model_c[r][c] = '0;
    for (int s = 0; s < k; s++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          pa = longint'($signed(beat_a[s][r]));
          pb = longint'($signed(beat_b[s][c]));
          model_c[r][c] = model_c[r][c] + acc_t'(pa * pb);
        end
  endtask

  function automatic logic [VW-1:0] model_row(input int r);
    logic [VW-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*ACC_W +: ACC_W] = model_c[r][c];
    return v;
  endfunction

  task automatic fill_random(input int n, input bit narrow);
    for (int s = 0; s < n; s++) begin
      for (int r = 0; r < ROWS; r++)
        beat_a[s][r] = narrow ? WIDTH'($signed(8'($urandom))) : WIDTH'($urandom);
      for (int c = 0; c < COLS; c++)
        beat_b[s][c] = narrow ? WIDTH'($signed(8'($urandom))) : WIDTH'($urandom);
    end
  endtask

  task automatic start_tile(input int k, input bit acc_mode);
    cfg_k   = KW'(k);
    cfg_acc = acc_mode;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy_after_start", VW'(busy), VW'(1));
    check_output("in_ready_after_start", VW'(in_ready), VW'(k != 0));
    check_output("out_valid_after_start", VW'(out_valid), VW'(k == 0));
  endtask

  // Present beats with random gaps and random start/cfg noise while loading
  task automatic feed_beats(input int n, input int valid_pct);
    int  idx;
    int  guard;
    bit  took;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 20000) begin
      in_valid = ($urandom_range(0, 99) < valid_pct);
      for (int r = 0; r < ROWS; r++)
        in_a[r*WIDTH +: WIDTH] = in_valid ? beat_a[idx][r] : WIDTH'($urandom);
      for (int c = 0; c < COLS; c++)
        in_b[c*WIDTH +: WIDTH] = in_valid ? beat_b[idx][c] : WIDTH'($urandom);
      start   = 1'($urandom);
      cfg_k   = KW'($urandom);
      cfg_acc = 1'($urandom);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check_output("beats_accepted", VW'(idx), VW'(n));
  endtask

  task automatic drain_rows(input int stall);
    int r;
    int guard;
    int stall_left;
    bit took;
    r = 0;
    guard = 0;
    stall_left = stall;
    while (r < ROWS && guard < 2000) begin
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'($urandom);
      end
      check_output("drain_out_valid", VW'(out_valid), VW'(1));
      check_output("drain_out_idx", VW'(out_idx), VW'(r));
      check_output($sformatf("row%0d", r), out_row, model_row(r));
      check_output("done_early", VW'(done), VW'(0));
      took = out_ready;
      @(posedge clk); #1;
      if (took) r++;
      guard++;
    end
    out_ready = 1'b0;
    check_output("rows_drained", VW'(r), VW'(ROWS));
    check_output("done_pulse", VW'(done), VW'(1));
    check_output("busy_after_drain", VW'(busy), VW'(0));
    check_output("out_valid_after_drain", VW'(out_valid), VW'(0));
    check_output("out_row_idle", out_row, VW'(0));
    @(posedge clk); #1;
    check_output("done_single", VW'(done), VW'(0));
  endtask

  // Full tile: model update, start, load, flush latency, drain
  task automatic apply_stimulus(input int k, input bit acc_mode, input int valid_pct, input int stall);
    int kk;
    int lat;
    kk = (k > KMAX) ? KMAX : k;
    model_tile(kk, acc_mode);
    start_tile(k, acc_mode);
    if (kk > 0) begin
      feed_beats(kk, valid_pct);
      check_output("in_ready_after_load", VW'(in_ready), VW'(0));
      lat = 1;
      while (!out_valid && lat < 64) begin
        @(posedge clk); #1;
        lat++;
      end
      check_output("drain_latency", VW'(lat), VW'(ROWS + COLS));
    end
    drain_rows(stall);
  endtask

  initial begin
    reset = 1'b0; cfg_k = '0; cfg_acc = 1'b0; start = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", VW'(busy), VW'(0));
    check_output("reset_in_ready", VW'(in_ready), VW'(0));
    check_output("reset_out_valid", VW'(out_valid), VW'(0));
    check_output("reset_done", VW'(done), VW'(0));
    check_output("reset_out_idx", VW'(out_idx), VW'(0));
    check_output("reset_out_row", out_row, VW'(0));
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model_c[r][c] = '0;
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] T1 single beat outer product");
    for (int r = 0; r < ROWS; r++) beat_a[0][r] = WIDTH'(r + 1);
    for (int c = 0; c < COLS; c++) beat_b[0][c] = WIDTH'(c + 5);
    apply_stimulus(1, 1'b0, 100, 0);

    $display("[TB] T4 accumulate then clear");
    apply_stimulus(1, 1'b1, 100, 0);
    apply_stimulus(1, 1'b0, 100, 0);

    $display("[TB] T2 random K=8 with gapped valid");
    fill_random(8, 1'b1);
    apply_stimulus(8, 1'b0, 50, 0);

    $display("[TB] T3 signed extremes");
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < ROWS; r++) beat_a[s][r] = 16'h7FFF;
      for (int c = 0; c < COLS; c++) beat_b[s][c] = 16'h7FFF;
    end
    apply_stimulus(2, 1'b0, 100, 0);
    check_output("t3_max_sq", VW'(model_c[ROWS-1][COLS-1]), VW'(40'h007FFE0002));
    for (int r = 0; r < ROWS; r++) beat_a[0][r] = 16'hFFFD;
    for (int c = 0; c < COLS; c++) beat_b[0][c] = 16'h0007;
    apply_stimulus(1, 1'b0, 100, 0);

    $display("[TB] T5 stalled drain and K=0 replay");
    fill_random(5, 1'b0);
    apply_stimulus(5, 1'b0, 70, 10);
    apply_stimulus(0, 1'b1, 100, 3);

    $display("[TB] clamp of oversize K");
    fill_random(KMAX, 1'b0);
    apply_stimulus(300, 1'b0, 100, 0);

    $display("[TB] T6 reset during load");
    fill_random(8, 1'b1);
    start_tile(8, 1'b0);
    feed_beats(3, 100);
    #2;
    reset = 1'b0;
    #1;
    check_output("midreset_busy", VW'(busy), VW'(0));
    check_output("midreset_in_ready", VW'(in_ready), VW'(0));
    check_output("midreset_out_valid", VW'(out_valid), VW'(0));
    check_output("midreset_done", VW'(done), VW'(0));
    check_output("midreset_out_idx", VW'(out_idx), VW'(0));
    check_output("midreset_out_row", out_row, VW'(0));
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model_c[r][c] = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    fill_random(8, 1'b1);
    apply_stimulus(8, 1'b1, 50, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
